game_sequencer: RTL and testbench
=================================

# game_sequencer

Turn sequencer for Wild Misere Tic Tac Toe. It sits between the keyboard ASCII decode and the board datapath, VGA plot engine and end checker. It collects a two-key move (cell digit, then letter), rejects illegal moves, commits the move to the board, and hands the cell to the plot engine. It then samples the end checker, alternates players and latches the game result.

## Interface

Parameters:
- FIRST_PLAYER, 2'b01, player who moves after reset and after a new game; 01 = P1, 10 = P2.
- CELL_X0, 20, x pixel of the top-left corner of cell 1.
- CELL_PITCH, 40, cell width and height in pixels.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  reset, synchronous and active-high despite the name.
- key_valid  in  1  one-cycle pulse; key_ascii is valid in that cycle.
- key_ascii  in  7  ASCII code of the pressed key.
- board  in  18  cell codes {s9,...,s1}, 2 bits each; s1 = board[1:0]; 00 empty, 01 B, 10 R.
- check  in  1  end checker: game ended (combinational on board).
- data_result  in  2  end checker: 11 = tie, anything else = line completed.
- wr_en  out  1  one-cycle board write strobe.
- wr_pos  out  4  cell 1–9 for the write.
- wr_data  out  2  letter code for the write.
- clr  out  1  one-cycle pulse to clear the board (new game).
- draw_req  out  1  plot request, held high until draw_done.
- draw_x  out  8  top-left x of the cell to plot.
- draw_y  out  7  top-left y of the cell to plot.
- draw_data  out  2  letter to plot.
- draw_done  in  1  one-cycle pulse from the plot engine.
- turn  out  2  player to move; 01 = P1, 10 = P2.
- err  out  1  one-cycle pulse on a rejected move.
- game_over  out  1  high while in S_OVER.
- winner  out  2  01 = P1, 10 = P2, 11 = tie; 00 while the game runs.

## Operation

Key decode:
- Digit: 0x31–0x39 maps to cells 1–9.
- Letter: 'B'/'b' (0x42/0x62) maps to 01; 'R'/'r' (0x52/0x72) maps to 10.
- Cancel: backspace 0x08.
- New game: 'N'/'n' (0x4E/0x6E).
- Any other key is ignored with no err.

States:
- S_POS: wait for a digit, latch it into pos_r, go to S_TYPE. Letters here pulse err and stay in S_POS.
- S_TYPE:
  - A digit overwrites pos_r.
  - Cancel returns to S_POS.
  - A letter checks the cell, board[2*(pos_r-1)+:2]:
    - Cell non-zero: pulse err, go to S_POS; turn is unchanged.
    - Cell empty: latch the letter into data_r, go to S_COMMIT.
- S_COMMIT:
  - Drive wr_en=1, wr_pos=pos_r, wr_data=data_r for exactly one cycle.
  - Load draw_x = CELL_X0 + CELL_PITCH*((pos_r-1)%3) and draw_y = CELL_PITCH*((pos_r-1)/3).
  - Go to S_DRAW.
- S_DRAW: draw_req=1 and draw_data=data_r. On draw_done go to S_CHECK.
- S_CHECK: sample check for one cycle.
  - check=0: toggle turn (01 and 10 swap), go to S_POS.
  - check=1 and data_result=11: winner=11, go to S_OVER.
  - check=1 otherwise: the player in turn loses (misere rule), so winner = the other player; go to S_OVER.
- S_OVER:
  - Holds game_over=1 and winner.
  - Only new game is accepted: pulse clr, set turn=FIRST_PLAYER, clear winner, go to S_POS.

Arithmetic:
- Coordinates are computed with the widths of draw_x/draw_y.
- With the defaults, x ∈ {20,60,100} and y ∈ {0,40,80}.
- The division and modulo use a 9-entry lookup, not dividers.

Reset:
- State goes to S_POS, turn=FIRST_PLAYER, pos_r=0, data_r=0.
- All pulse outputs, draw_req, draw_x, draw_y, draw_data, game_over and winner go to 0.

## Timing

- Key-to-decision: a key_valid in cycle T produces its state change and any err pulse at edge T+1.
- From the letter key_valid at T: wr_en is high in T+1, and draw_req rises at T+2.
- The board updates at the edge after wr_en, so check is valid by S_CHECK. draw_done is never accepted in the same cycle draw_req rises, which guarantees at least one cycle of board settling.
- draw_req stays high until the cycle of draw_done. It falls the next cycle; the plot engine must not need a second acknowledge.
- key_valid is dropped in S_COMMIT, S_DRAW and S_CHECK: no buffering, no err.
- draw_done outside S_DRAW is ignored.
- Reset asserted mid-S_DRAW: draw_req is low the next cycle, and a late draw_done is ignored.
- Reset has priority over key_valid in the same cycle.
- wr_en and clr are never high in the same cycle.

## Test plan

- Basic move: reset, keys '5','B' → one wr_en pulse with wr_pos=5 and wr_data=01; draw_x=60, draw_y=40; after draw_done, turn=10.
- Occupied cell: s5=01 on the board, turn=10, keys '5','R' → err pulse, no wr_en, turn stays 10, state returns to S_POS.
- Edit and cancel: keys '3','7','r' → wr_pos=7, wr_data=10. Keys '2', backspace, 'B' → err on the 'B', no write.
- Misere loss: turn=01, board completes a row with check=1 and data_result=01 → winner=10, game_over=1. Key 'N' → clr pulse, turn=01, winner=00.
- Tie: last empty cell filled, check=1, data_result=11 → winner=11. Digit keys in S_OVER → no err, no write.
- Reset mid-draw: resetn high while draw_req=1 → next cycle draw_req=0, turn=FIRST_PLAYER; a draw_done after reset leaves the state at S_POS.

Source files
------------

// File: rtl/game_sequencer.sv
// Turn sequencer for Wild Misere Tic Tac Toe: collects a digit+letter move, validates it,
// commits it to the board, hands the cell to the plot engine and tracks turn and result.
module game_sequencer #(
  parameter logic [1:0] FIRST_PLAYER = 2'b01,
  parameter int         CELL_X0      = 20,
  parameter int         CELL_PITCH   = 40
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        key_valid,
  input  logic [6:0]  key_ascii,
  input  logic [17:0] board,
  input  logic        check,
  input  logic [1:0]  data_result,
  output logic        wr_en,
  output logic [3:0]  wr_pos,
  output logic [1:0]  wr_data,
  output logic        clr,
  output logic        draw_req,
  output logic [7:0]  draw_x,
  output logic [6:0]  draw_y,
  output logic [1:0]  draw_data,
  input  logic        draw_done,
  output logic [1:0]  turn,
  output logic        err,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [2:0] S_POS    = 3'd0;
  localparam logic [2:0] S_TYPE   = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_DRAW   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_OVER   = 3'd5;

  localparam logic [7:0] X_COL0 = 8'(CELL_X0);
  localparam logic [7:0] X_COL1 = 8'(CELL_X0 + CELL_PITCH);
  localparam logic [7:0] X_COL2 = 8'(CELL_X0 + 2 * CELL_PITCH);
  localparam logic [6:0] Y_ROW0 = 7'd0;
  localparam logic [6:0] Y_ROW1 = 7'(CELL_PITCH);
  localparam logic [6:0] Y_ROW2 = 7'(2 * CELL_PITCH);

  logic [2:0] state_q, state_d;
  logic [1:0] turn_q, turn_d;
  logic [3:0] pos_q, pos_d;
  logic [1:0] data_q, data_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] drawX_q, drawX_d;
  logic [6:0] drawY_q, drawY_d;
  logic       err_q, err_d;
  logic       clr_q, clr_d;
  logic       drawSeen_q;

  logic       isDigit, isLetter, isCancel, isNew;
  logic [1:0] letterCode;
  logic [1:0] cellCode;
  logic [7:0] lookX;
  logic [6:0] lookY;

  always_comb begin
    isDigit    = (key_ascii >= 7'h31) && (key_ascii <= 7'h39);
    isCancel   = (key_ascii == 7'h08);
    isNew      = (key_ascii == 7'h4E) || (key_ascii == 7'h6E);
    letterCode = 2'b00;
    if ((key_ascii == 7'h42) || (key_ascii == 7'h62)) letterCode = 2'b01;
    if ((key_ascii == 7'h52) || (key_ascii == 7'h72)) letterCode = 2'b10;
    isLetter   = (letterCode != 2'b00);
  end

  assign cellCode = 2'(board >> {pos_q - 4'd1, 1'b0});

  // Cell-to-pixel lookup replaces the divide/modulo by three.
  always_comb begin
    lookX = 8'd0;
    lookY = 7'd0;
    case (pos_q)
      4'd1: begin lookX = X_COL0; lookY = Y_ROW0; end
      4'd2: begin lookX = X_COL1; lookY = Y_ROW0; end
      4'd3: begin lookX = X_COL2; lookY = Y_ROW0; end
      4'd4: begin lookX = X_COL0; lookY = Y_ROW1; end
      4'd5: begin lookX = X_COL1; lookY = Y_ROW1; end
      4'd6: begin lookX = X_COL2; lookY = Y_ROW1; end
      4'd7: begin lookX = X_COL0; lookY = Y_ROW2; end
      4'd8: begin lookX = X_COL1; lookY = Y_ROW2; end
      4'd9: begin lookX = X_COL2; lookY = Y_ROW2; end
      default: begin lookX = 8'd0; lookY = 7'd0; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    pos_d    = pos_q;
    data_d   = data_q;
    winner_d = winner_q;
    drawX_d  = drawX_q;
    drawY_d  = drawY_q;
    err_d    = 1'b0;
    clr_d    = 1'b0;
    case (state_q)
      S_POS: begin
        if (key_valid) begin
          if (isDigit) begin
            pos_d   = key_ascii[3:0];
            state_d = S_TYPE;
          end else if (isLetter) begin
            err_d = 1'b1;
          end
        end
      end
      S_TYPE: begin
        if (key_valid) begin
          if (isDigit) begin
            pos_d = key_ascii[3:0];
          end else if (isCancel) begin
            state_d = S_POS;
          end else if (isLetter) begin
            if (cellCode != 2'b00) begin
              err_d   = 1'b1;
              state_d = S_POS;
            end else begin
              data_d  = letterCode;
              state_d = S_COMMIT;
            end
          end
        end
      end
      S_COMMIT: begin
        drawX_d = lookX;
        drawY_d = lookY;
        state_d = S_DRAW;
      end
      // The first S_DRAW cycle ignores draw_done so the board write has settled.
      S_DRAW: begin
        if (draw_done && drawSeen_q) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_OVER;
        if (!check) begin
          turn_d  = {turn_q[0], turn_q[1]};
          state_d = S_POS;
        end else if (data_result == 2'b11) begin
          winner_d = 2'b11;
        end else begin
          winner_d = {turn_q[0], turn_q[1]};
        end
      end
      S_OVER: begin
        if (key_valid && isNew) begin
          clr_d    = 1'b1;
          turn_d   = FIRST_PLAYER;
          winner_d = 2'b00;
          state_d  = S_POS;
        end
      end
      default: state_d = S_POS;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q    <= S_POS;
      turn_q     <= FIRST_PLAYER;
      pos_q      <= 4'd0;
      data_q     <= 2'b00;
      winner_q   <= 2'b00;
      drawX_q    <= 8'd0;
      drawY_q    <= 7'd0;
      err_q      <= 1'b0;
      clr_q      <= 1'b0;
      drawSeen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      pos_q      <= pos_d;
      data_q     <= data_d;
      winner_q   <= winner_d;
      drawX_q    <= drawX_d;
      drawY_q    <= drawY_d;
      err_q      <= err_d;
      clr_q      <= clr_d;
      drawSeen_q <= (state_q == S_DRAW);
    end
  end

  assign wr_en     = (state_q == S_COMMIT);
  assign wr_pos    = wr_en ? pos_q : 4'd0;
  assign wr_data   = wr_en ? data_q : 2'b00;
  assign draw_req  = (state_q == S_DRAW);
  assign draw_data = draw_req ? data_q : 2'b00;
  assign draw_x    = drawX_q;
  assign draw_y    = drawY_q;
  assign clr       = clr_q;
  assign err       = err_q;
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: emulates board RAM and end checker, and predicts
// every move outcome from a cell-array model of the game rules.
module tb_game_sequencer;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        key_valid = 1'b0;
  logic [6:0]  key_ascii = 7'd0;
  logic [17:0] board;
  logic        check;
  logic [1:0]  data_result;
  logic        wr_en, clr, draw_req, err, game_over;
  logic [3:0]  wr_pos;
  logic [1:0]  wr_data, draw_data, turn, winner;
  logic [7:0]  draw_x;
  logic [6:0]  draw_y;
  logic        draw_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] envCell   [1:9];
  logic [1:0] modelCell [1:9];
  logic [1:0] modelTurn;
  logic [1:0] modelWinner;
  bit         modelOver;
  logic [1:0] envRes;

  always #5 clock = ~clock;

  game_sequencer dut (
    .clock(clock), .resetn(resetn), .key_valid(key_valid), .key_ascii(key_ascii),
    .board(board), .check(check), .data_result(data_result),
    .wr_en(wr_en), .wr_pos(wr_pos), .wr_data(wr_data), .clr(clr),
    .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_data(draw_data),
    .draw_done(draw_done), .turn(turn), .err(err), .game_over(game_over), .winner(winner)
  );

  // 0 = game running, 01 = some line of three equal letters, 11 = full board without a line.
  function automatic logic [1:0] evalCells(input logic [1:0] c [1:9]);
    int lines [8][3];
    bit full;
    lines = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7}, '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
    for (int i = 0; i < 8; i++)
      if (c[lines[i][0]] != 2'b00 && c[lines[i][0]] == c[lines[i][1]] && c[lines[i][1]] == c[lines[i][2]])
        return 2'b01;
    full = 1'b1;
    for (int k = 1; k <= 9; k++) if (c[k] == 2'b00) full = 1'b0;
    return full ? 2'b11 : 2'b00;
  endfunction

  // Board datapath and end checker stand-ins.
  always @(posedge clock) begin
    if (resetn || clr) begin
      for (int k = 1; k <= 9; k++) envCell[k] <= 2'b00;
    end else if (wr_en && wr_pos >= 4'd1 && wr_pos <= 4'd9) begin
      envCell[wr_pos] <= wr_data;
    end
  end

  assign board = {envCell[9], envCell[8], envCell[7], envCell[6], envCell[5],
                  envCell[4], envCell[3], envCell[2], envCell[1]};
  assign envRes      = evalCells(envCell);
  assign check       = (envRes != 2'b00);
  assign data_result = envRes;

  task automatic modelReset();
    for (int k = 1; k <= 9; k++) modelCell[k] = 2'b00;
    modelTurn   = 2'b01;
    modelWinner = 2'b00;
    modelOver   = 1'b0;
  endtask

  task automatic pressKey(input logic [6:0] a);
    @(negedge clock);
    key_valid = 1'b1;
    key_ascii = a;
    @(negedge clock);
    key_valid = 1'b0;
    key_ascii = 7'd0;
  endtask

  // Letter key for an already-selected cell p, followed by the full plot handshake.
  task automatic commitLetter(input int p, input logic [6:0] letter);
    logic [1:0] code;
    logic [1:0] res;
    int expX, expY;
    code = (letter == 7'h42 || letter == 7'h62) ? 2'b01 : 2'b10;
    pressKey(letter);
    if (modelCell[p] != 2'b00) begin
      vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL occupied_err: got %b want 1", err); end
      vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL occupied_wr: got %b want 0", wr_en); end
      @(negedge clock);
      vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_pulse_width: got %b want 0", err); end
      vectors++; if (turn !== modelTurn) begin miscompares++; $display("[TB] FAIL occupied_turn: got %b want %b", turn, modelTurn); end
      return;
    end
    expX = 20 + 40 * ((p - 1) % 3);
    expY = 40 * ((p - 1) / 3);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL move_err: got %b want 0", err); end
    vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_en: got %b want 1", wr_en); end
    vectors++; if (wr_pos !== 4'(p)) begin miscompares++; $display("[TB] FAIL wr_pos: got %0d want %0d", wr_pos, p); end
    vectors++; if (wr_data !== code) begin miscompares++; $display("[TB] FAIL wr_data: got %b want %b", wr_data, code); end
    @(negedge clock);
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_en_width: got %b want 0", wr_en); end
    vectors++; if (draw_req !== 1'b1) begin miscompares++; $display("[TB] FAIL draw_req_rise: got %b want 1", draw_req); end
    vectors++; if (draw_x !== 8'(expX)) begin miscompares++; $display("[TB] FAIL draw_x: got %0d want %0d", draw_x, expX); end
    vectors++; if (draw_y !== 7'(expY)) begin miscompares++; $display("[TB] FAIL draw_y: got %0d want %0d", draw_y, expY); end
    vectors++; if (draw_data !== code) begin miscompares++; $display("[TB] FAIL draw_data: got %b want %b", draw_data, code); end
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    vectors++; if (draw_req !== 1'b1) begin miscompares++; $display("[TB] FAIL early_done_ignored: got %b want 1", draw_req); end
    repeat ($urandom_range(0, 2)) @(negedge clock);
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    vectors++; if (draw_req !== 1'b0) begin miscompares++; $display("[TB] FAIL draw_req_fall: got %b want 0", draw_req); end
    modelCell[p] = code;
    vectors++; if (envCell[p] !== code) begin miscompares++; $display("[TB] FAIL board_write: got %b want %b", envCell[p], code); end
    res = evalCells(modelCell);
    @(negedge clock);
    if (res == 2'b00) begin
      modelTurn = (modelTurn == 2'b01) ? 2'b10 : 2'b01;
    end else begin
      modelWinner = (res == 2'b11) ? 2'b11 : ((modelTurn == 2'b01) ? 2'b10 : 2'b01);
      modelOver   = 1'b1;
    end
    vectors++; if (turn !== modelTurn) begin miscompares++; $display("[TB] FAIL turn_after_move: got %b want %b", turn, modelTurn); end
    vectors++; if (winner !== modelWinner) begin miscompares++; $display("[TB] FAIL winner: got %b want %b", winner, modelWinner); end
    vectors++; if (game_over !== modelOver) begin miscompares++; $display("[TB] FAIL game_over: got %b want %b", game_over, modelOver); end
  endtask

  task automatic playMove(input int p, input logic [6:0] letter);
    pressKey(7'(48 + p));
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL digit_err: got %b want 0", err); end
    commitLetter(p, letter);
  endtask

  task automatic newGame(input logic [6:0] a);
    pressKey(a);
    vectors++; if (clr !== 1'b1) begin miscompares++; $display("[TB] FAIL clr_pulse: got %b want 1", clr); end
    vectors++; if (turn !== 2'b01) begin miscompares++; $display("[TB] FAIL new_turn: got %b want 01", turn); end
    vectors++; if (winner !== 2'b00) begin miscompares++; $display("[TB] FAIL new_winner: got %b want 00", winner); end
    vectors++; if (game_over !== 1'b0) begin miscompares++; $display("[TB] FAIL new_game_over: got %b want 0", game_over); end
    @(negedge clock);
    vectors++; if (clr !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_width: got %b want 0", clr); end
    vectors++; if (board !== 18'd0) begin miscompares++; $display("[TB] FAIL board_cleared: got %h want 0", board); end
    modelReset();
  endtask

  task automatic test_reset();
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    modelReset();
    @(negedge clock);
    vectors++; if (turn !== 2'b01) begin miscompares++; $display("[TB] FAIL reset_turn: got %b want 01", turn); end
    vectors++; if ({winner, game_over, err, clr, wr_en, draw_req} !== 7'd0) begin miscompares++; $display("[TB] FAIL reset_flags: got %b want 0", {winner, game_over, err, clr, wr_en, draw_req}); end
    vectors++; if ({draw_x, draw_y, draw_data} !== 17'd0) begin miscompares++; $display("[TB] FAIL reset_draw: got %h want 0", {draw_x, draw_y, draw_data}); end
  endtask

  task automatic test_basic_move();
    playMove(5, 7'h42);
    vectors++; if (turn !== 2'b10) begin miscompares++; $display("[TB] FAIL basic_turn: got %b want 10", turn); end
  endtask

  task automatic test_occupied();
    playMove(5, 7'h52);
    pressKey(7'h42);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL back_in_pos: got %b want 1", err); end
  endtask

  task automatic test_edit_cancel();
    pressKey(7'h33);
    playMove(7, 7'h72);
    pressKey(7'h32);
    pressKey(7'h08);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL cancel_err: got %b want 0", err); end
    pressKey(7'h42);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL after_cancel_err: got %b want 1", err); end
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL after_cancel_wr: got %b want 0", wr_en); end
  endtask

  task automatic test_ignored_keys();
    pressKey(7'h78);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL other_key_err: got %b want 0", err); end
    pressKey(7'h4E);
    vectors++; if ({err, clr} !== 2'b00) begin miscompares++; $display("[TB] FAIL new_in_pos: got %b want 00", {err, clr}); end
    pressKey(7'h34);
    pressKey(7'h51);
    pressKey(7'h6E);
    vectors++; if ({err, clr} !== 2'b00) begin miscompares++; $display("[TB] FAIL keys_in_type: got %b want 00", {err, clr}); end
    commitLetter(4, 7'h62);
  endtask

  task automatic test_over_keys();
    pressKey(7'(48 + $urandom_range(1, 9)));
    vectors++; if ({err, wr_en} !== 2'b00) begin miscompares++; $display("[TB] FAIL over_digit: got %b want 00", {err, wr_en}); end
    pressKey(7'h42);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL over_letter_err: got %b want 0", err); end
    @(negedge clock);
    vectors++; if ({wr_en, game_over} !== 2'b01) begin miscompares++; $display("[TB] FAIL over_hold: got %b want 01", {wr_en, game_over}); end
    vectors++; if (winner !== modelWinner) begin miscompares++; $display("[TB] FAIL over_winner: got %b want %b", winner, modelWinner); end
  endtask

  task automatic test_misere_loss();
    test_reset();
    playMove(1, 7'h42); playMove(4, 7'h52); playMove(2, 7'h42);
    playMove(5, 7'h52); playMove(3, 7'h42);
    vectors++; if ({winner, game_over} !== 3'b101) begin miscompares++; $display("[TB] FAIL misere_result: got %b want 101", {winner, game_over}); end
    newGame(7'h4E);
  endtask

  task automatic test_tie();
    logic [6:0] letters [1:9];
    letters = '{7'h42, 7'h52, 7'h42, 7'h42, 7'h52, 7'h52, 7'h52, 7'h42, 7'h42};
    for (int p = 1; p <= 9; p++) playMove(p, letters[p]);
    vectors++; if ({winner, game_over} !== 3'b111) begin miscompares++; $display("[TB] FAIL tie_result: got %b want 111", {winner, game_over}); end
    test_over_keys();
    newGame(7'h6E);
  endtask

  task automatic test_random_games();
    logic [6:0] letterSet [4];
    int p, iter;
    letterSet = '{7'h42, 7'h62, 7'h52, 7'h72};
    for (int g = 0; g < 6; g++) begin
      iter = 0;
      while (!modelOver && iter < 100) begin
        iter++;
        p = $urandom_range(1, 9);
        if ($urandom_range(0, 4) != 0) begin
          for (int s = 0; s < 9 && modelCell[p] != 2'b00; s++) p = (p % 9) + 1;
        end
        if ($urandom_range(0, 5) == 0) begin
          pressKey(7'(48 + $urandom_range(1, 9)));
          pressKey(7'h08);
          vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_cancel: got %b want 0", err); end
        end
        playMove(p, letterSet[$urandom_range(0, 3)]);
      end
      vectors++; if (!modelOver) begin miscompares++; $display("[TB] FAIL rand_game_end: got %0d moves want game over", iter); end
      test_over_keys();
      newGame(($urandom_range(0, 1) == 0) ? 7'h4E : 7'h6E);
    end
  endtask

  task automatic test_reset_mid_draw();
    pressKey(7'h31);
    pressKey(7'h52);
    @(negedge clock);
    vectors++; if (draw_req !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_draw_req: got %b want 1", draw_req); end
    resetn = 1'b1;
    @(negedge clock);
    resetn = 1'b0;
    modelReset();
    vectors++; if (draw_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_draw_req: got %b want 0", draw_req); end
    vectors++; if (turn !== 2'b01) begin miscompares++; $display("[TB] FAIL reset_draw_turn: got %b want 01", turn); end
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    @(negedge clock);
    vectors++; if ({draw_req, wr_en, game_over} !== 3'b000) begin miscompares++; $display("[TB] FAIL late_done: got %b want 000", {draw_req, wr_en, game_over}); end
    pressKey(7'h42);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL late_done_state: got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_occupied();
    test_edit_cancel();
    test_ignored_keys();
    test_misere_loss();
    test_tie();
    test_random_games();
    test_reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
